// File: rtl/sdram_arbiter.sv
// sdram_arbiter: serialises loader, instruction-fetch and data requests onto
// the single sdram_ctl command port. One transaction in flight at a time,
// round-robin among eligible ports, with a watchdog that aborts commands the
// controller never completes.
module sdram_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata2,
    output logic [2:0]        ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              timeout_seen,
    output logic              ctl_start,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_din,
    input  logic [DATA_W-1:0] ctl_dout,
    input  logic              ctl_done
);

    // Watchdog wide enough to hold TIMEOUT itself.
    localparam int              WD_W   = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        id_q, id_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tseen_q, tseen_d;
    logic [1:0]        last_q, last_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic [2:0]        elig;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic [WD_W-1:0]   wdog_inc;

    // Round-robin pick: search starts after the last served port and skips
    // ports that are not eligible under the current load_en mode.
    always_comb begin
        elig        = req & (load_en ? 3'b001 : 3'b110);
        grant_valid = |elig;
        grant_id    = 2'd0;
        case (last_q)
            2'd0: begin
                if (elig[1])      grant_id = 2'd1;
                else if (elig[2]) grant_id = 2'd2;
                else              grant_id = 2'd0;
            end
            2'd1: begin
                if (elig[2])      grant_id = 2'd2;
                else if (elig[0]) grant_id = 2'd0;
                else              grant_id = 2'd1;
            end
            default: begin
                if (elig[0])      grant_id = 2'd0;
                else if (elig[1]) grant_id = 2'd1;
                else              grant_id = 2'd2;
            end
        endcase
    end

    // Next-state logic: latch the winner in IDLE, count the watchdog in WAIT.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        tseen_d  = tseen_q;
        last_d   = last_q;
        wdog_d   = wdog_q;
        wdog_inc = wdog_q + WD_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    id_d    = grant_id;
                    // Instruction fetch is read-only regardless of its we bit.
                    we_d    = we[grant_id] & (grant_id != 2'd1);
                    state_d = ST_ISSUE;
                    case (grant_id)
                        2'd0: begin
                            addr_d = addr0;
                            din_d  = wdata0;
                        end
                        2'd1: begin
                            addr_d = addr1;
                            din_d  = '0;
                        end
                        default: begin
                            addr_d = addr2;
                            din_d  = wdata2;
                        end
                    endcase
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctl_done) begin
                    rdata_d = ctl_dout;
                    err_d   = 1'b0;
                    state_d = ST_ACK;
                end else if (wdog_inc == WD_MAX) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tseen_d = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    wdog_d = wdog_inc;
                end
            end
            default: begin
                last_d  = id_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            tseen_q <= 1'b0;
            last_q  <= 2'd2;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            tseen_q <= tseen_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
        end
    end

    // Outputs decoded from state; command fields are zero while idle.
    always_comb begin
        ack          = '0;
        err          = 1'b0;
        busy         = (state_q != ST_IDLE);
        ctl_start    = (state_q == ST_ISSUE);
        ctl_we       = 1'b0;
        ctl_addr     = '0;
        ctl_din      = '0;
        rdata        = rdata_q;
        timeout_seen = tseen_q;
        if (state_q != ST_IDLE) begin
            ctl_we   = we_q;
            ctl_addr = addr_q;
            ctl_din  = din_q;
        end
        if (state_q == ST_ACK) begin
            ack = 3'b001 << id_q;
            err = err_q;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a simple SDRAM model that answers
// each command with ctl_done in the first WAIT cycle when enabled.
module tb_sdram_arbiter;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [15:0] addr0, addr1, addr2;
    logic [15:0] wdata0, wdata2;
    logic [2:0]  ack;
    logic        err;
    logic [15:0] rdata;
    logic        busy;
    logic        timeout_seen;
    logic        ctl_start;
    logic        ctl_we;
    logic [15:0] ctl_addr;
    logic [15:0] ctl_din;
    logic [15:0] ctl_dout;
    logic        ctl_done;

    logic        model_en;
    logic        model_done;
    logic [15:0] model_dout;
    logic        stray_done;
    logic [15:0] mem [256];

    int          start_cnt;
    int          ack_cnt;
    logic        start_we;
    logic        multi_ack;

    int          total;
    int          bad;

    assign ctl_done = model_done | stray_done;
    assign ctl_dout = model_dout;

    sdram_arbiter #(
        .ADDR_W (16),
        .DATA_W (16),
        .TIMEOUT(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .req         (req),
        .we          (we),
        .addr0       (addr0),
        .addr1       (addr1),
        .addr2       (addr2),
        .wdata0      (wdata0),
        .wdata2      (wdata2),
        .ack         (ack),
        .err         (err),
        .rdata       (rdata),
        .busy        (busy),
        .timeout_seen(timeout_seen),
        .ctl_start   (ctl_start),
        .ctl_we      (ctl_we),
        .ctl_addr    (ctl_addr),
        .ctl_din     (ctl_din),
        .ctl_dout    (ctl_dout),
        .ctl_done    (ctl_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SDRAM model: command taken at the end of ISSUE, done in the next cycle.
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (ctl_start && model_en) begin
            if (ctl_we) mem[ctl_addr[7:0]] <= ctl_din;
            model_dout <= ctl_we ? 16'h0000 : mem[ctl_addr[7:0]];
            model_done <= 1'b1;
        end
    end

    // Activity monitor: counts starts/acks, records issued we, flags multi-ack.
    always @(posedge clk) begin
        if (ctl_start) begin
            start_cnt <= start_cnt + 1;
            start_we  <= ctl_we;
        end
        if (ack != 3'b000) ack_cnt <= ack_cnt + 1;
        if ($countones(ack) > 1) multi_ack <= 1'b1;
    end

    task automatic wait_ack(output int cyc, output logic [2:0] a, output logic e,
                            output logic [15:0] rd);
        logic found;
        found = 1'b0;
        cyc   = -1;
        a     = '0;
        e     = 1'b0;
        rd    = '0;
        for (int i = 1; i <= 40; i++) begin
            if (!found) begin
                @(negedge clk);
                if (ack !== 3'b000) begin
                    found = 1'b1;
                    cyc   = i;
                    a     = ack;
                    e     = err;
                    rd    = rdata;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b want=000", ack); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (timeout_seen !== 1'b0) begin bad++; $display("FAIL reset_tseen got=%b want=0", timeout_seen); end
        total++; if (ctl_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", ctl_start); end
        total++; if ({ctl_we, ctl_addr, ctl_din} !== 33'd0) begin
            bad++; $display("FAIL reset_cmd got we=%b addr=%h din=%h want all 0", ctl_we, ctl_addr, ctl_din);
        end
    endtask

    task automatic test_loader_write;
        int          cyc;
        logic [2:0]  a;
        logic        e;
        logic [15:0] rd;
        int          s0;
        s0      = start_cnt;
        load_en = 1'b1;
        req     = 3'b001;
        we      = 3'b001;
        addr0   = 16'h0001;
        wdata0  = 16'h9825;
        @(negedge clk);
        total++; if (ctl_start !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL ld_issue got start=%b busy=%b want 1 1", ctl_start, busy);
        end
        total++; if (ctl_we !== 1'b1 || ctl_addr !== 16'h0001 || ctl_din !== 16'h9825) begin
            bad++; $display("FAIL ld_cmd got we=%b addr=%h din=%h want 1 0001 9825", ctl_we, ctl_addr, ctl_din);
        end
        wait_ack(cyc, a, e, rd);
        total++; if (cyc != 2 || a !== 3'b001 || e !== 1'b0) begin
            bad++; $display("FAIL ld_ack got cyc=%0d ack=%b err=%b want 2 001 0", cyc, a, e);
        end
        // back-to-back loader writes with new address/data presented at ack
        addr0  = 16'h0010;
        wdata0 = 16'h1234;
        wait_ack(cyc, a, e, rd);
        total++; if (cyc != 4 || a !== 3'b001 || e !== 1'b0) begin
            bad++; $display("FAIL ld_b2b1 got cyc=%0d ack=%b err=%b want 4 001 0", cyc, a, e);
        end
        addr0  = 16'h0020;
        wdata0 = 16'hABCD;
        wait_ack(cyc, a, e, rd);
        total++; if (cyc != 4 || a !== 3'b001) begin
            bad++; $display("FAIL ld_b2b2 got cyc=%0d ack=%b want 4 001", cyc, a);
        end
        req = 3'b000;
        @(negedge clk);
        @(negedge clk);
        total++; if (start_cnt - s0 != 3) begin bad++; $display("FAIL ld_starts got=%0d want=3", start_cnt - s0); end
        total++; if (mem[1] !== 16'h9825 || mem[16] !== 16'h1234 || mem[32] !== 16'hABCD) begin
            bad++; $display("FAIL ld_mem got %h %h %h want 9825 1234 abcd", mem[1], mem[16], mem[32]);
        end
    endtask

    task automatic test_round_robin;
        int          cyc;
        logic [2:0]  a;
        logic        e;
        logic [15:0] rd;
        logic [2:0]  exp_a [4];
        logic [15:0] exp_d [4];
        exp_a   = '{3'b010, 3'b100, 3'b010, 3'b100};
        exp_d   = '{16'hABCD, 16'h1234, 16'hABCD, 16'h1234};
        load_en = 1'b0;
        req     = 3'b110;
        we      = 3'b010;
        addr1   = 16'h0020;
        addr2   = 16'h0010;
        wdata2  = 16'h5555;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc, a, e, rd);
            total++; if (a !== exp_a[k] || e !== 1'b0 || rd !== exp_d[k]) begin
                bad++; $display("FAIL rr_grant%0d got ack=%b err=%b rdata=%h want %b 0 %h",
                                k, a, e, rd, exp_a[k], exp_d[k]);
            end
            total++; if (cyc != ((k == 0) ? 3 : 4) || start_we !== 1'b0) begin
                bad++; $display("FAIL rr_timing%0d got cyc=%0d we=%b want %0d 0",
                                k, cyc, start_we, (k == 0) ? 3 : 4);
            end
        end
        req = 3'b000;
        we  = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_masking;
        int s0;
        s0 = start_cnt;
        load_en = 1'b1;
        req     = 3'b110;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || ctl_start !== 1'b0) begin
                bad++; $display("FAIL mask_cpu%0d got busy=%b start=%b want 0 0", k, busy, ctl_start);
            end
        end
        load_en = 1'b0;
        req     = 3'b001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || ctl_start !== 1'b0) begin
                bad++; $display("FAIL mask_ld%0d got busy=%b start=%b want 0 0", k, busy, ctl_start);
            end
        end
        total++; if (start_cnt != s0) begin bad++; $display("FAIL mask_starts got=%0d want=%0d", start_cnt, s0); end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int          cyc;
        logic [2:0]  a;
        logic        e;
        logic [15:0] rd;
        model_en = 1'b0;
        load_en  = 1'b1;
        req      = 3'b001;
        we       = 3'b000;
        addr0    = 16'h0005;
        @(negedge clk);
        total++; if (ctl_start !== 1'b1) begin bad++; $display("FAIL to_issue got=%b want=1", ctl_start); end
        wait_ack(cyc, a, e, rd);
        total++; if (cyc != 9 || a !== 3'b001 || e !== 1'b1) begin
            bad++; $display("FAIL to_ack got cyc=%0d ack=%b err=%b want 9 001 1", cyc, a, e);
        end
        total++; if (rd !== 16'h0000 || timeout_seen !== 1'b1) begin
            bad++; $display("FAIL to_flags got rdata=%h tseen=%b want 0000 1", rd, timeout_seen);
        end
        model_en = 1'b1;
        addr0    = 16'h0001;
        wait_ack(cyc, a, e, rd);
        total++; if (a !== 3'b001 || e !== 1'b0 || rd !== 16'h9825 || timeout_seen !== 1'b1) begin
            bad++; $display("FAIL to_next got ack=%b err=%b rdata=%h tseen=%b want 001 0 9825 1",
                            a, e, rd, timeout_seen);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        int          cyc;
        logic [2:0]  a;
        logic        e;
        logic [15:0] rd;
        int          acks0;
        // serve port 1 so that, without reset, port 2 would win next
        load_en = 1'b0;
        req     = 3'b010;
        addr1   = 16'h0020;
        wait_ack(cyc, a, e, rd);
        total++; if (a !== 3'b010) begin bad++; $display("FAIL rw_pre got=%b want=010", a); end
        model_en = 1'b0;
        req      = 3'b100;
        addr2    = 16'h0010;
        @(negedge clk);   // IDLE
        @(negedge clk);   // ISSUE
        @(negedge clk);   // WAIT
        total++; if (busy !== 1'b1 || ctl_start !== 1'b0) begin
            bad++; $display("FAIL rw_inwait got busy=%b start=%b want 1 0", busy, ctl_start);
        end
        acks0 = ack_cnt;
        rst   = 1'b1;
        @(negedge clk);
        total++; if (ack !== 3'b000 || err !== 1'b0 || rdata !== 16'h0000 || busy !== 1'b0 ||
                     timeout_seen !== 1'b0) begin
            bad++; $display("FAIL rw_out got ack=%b err=%b rdata=%h busy=%b tseen=%b want 000 0 0000 0 0",
                            ack, err, rdata, busy, timeout_seen);
        end
        total++; if (ctl_start !== 1'b0 || ctl_we !== 1'b0 || ctl_addr !== 16'h0000 || ctl_din !== 16'h0000) begin
            bad++; $display("FAIL rw_cmd got start=%b we=%b addr=%h din=%h want all 0",
                            ctl_start, ctl_we, ctl_addr, ctl_din);
        end
        rst      = 1'b0;
        model_en = 1'b1;
        req      = 3'b110;
        wait_ack(cyc, a, e, rd);
        total++; if (a !== 3'b010 || cyc != 3) begin
            bad++; $display("FAIL rw_first got ack=%b cyc=%0d want 010 3", a, cyc);
        end
        total++; if (ack_cnt - acks0 != 0) begin
            bad++; $display("FAIL rw_noack got=%0d want=0", ack_cnt - acks0);
        end
        req = 3'b000;
        @(negedge clk);
        load_en = 1'b1;
        req     = 3'b001;
        addr0   = 16'h0001;
        wait_ack(cyc, a, e, rd);
        total++; if (a !== 3'b001 || rd !== 16'h9825) begin
            bad++; $display("FAIL rw_port0 got ack=%b rdata=%h want 001 9825", a, rd);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_stray_done;
        int          cyc;
        logic [2:0]  a;
        logic        e;
        logic [15:0] rd;
        int          s0;
        int          acks0;
        s0         = start_cnt;
        acks0      = ack_cnt;
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || ack !== 3'b000 || start_cnt != s0 || ack_cnt != acks0) begin
            bad++; $display("FAIL sd_idle got busy=%b ack=%b starts=%0d acks=%0d want 0 000 %0d %0d",
                            busy, ack, start_cnt, ack_cnt, s0, acks0);
        end
        model_en = 1'b0;
        load_en  = 1'b1;
        req      = 3'b001;
        addr0    = 16'h0001;
        @(negedge clk);
        total++; if (ctl_start !== 1'b1) begin bad++; $display("FAIL sd_issue got=%b want=1", ctl_start); end
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        total++; if (busy !== 1'b1 || ack !== 3'b000) begin
            bad++; $display("FAIL sd_wait got busy=%b ack=%b want 1 000", busy, ack);
        end
        wait_ack(cyc, a, e, rd);
        total++; if (cyc != 8 || a !== 3'b001 || e !== 1'b1) begin
            bad++; $display("FAIL sd_abort got cyc=%0d ack=%b err=%b want 8 001 1", cyc, a, e);
        end
        req      = 3'b000;
        model_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_onehot;
        total++; if (multi_ack !== 1'b0) begin bad++; $display("FAIL ack_onehot got=%b want=0", multi_ack); end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        start_cnt  = 0;
        ack_cnt    = 0;
        start_we   = 1'b0;
        multi_ack  = 1'b0;
        model_en   = 1'b1;
        model_done = 1'b0;
        model_dout = 16'h0000;
        stray_done = 1'b0;
        rst        = 1'b1;
        load_en    = 1'b0;
        req        = 3'b000;
        we         = 3'b000;
        addr0      = '0;
        addr1      = '0;
        addr2      = '0;
        wdata0     = '0;
        wdata2     = '0;

        test_reset();
        test_loader_write();
        test_round_robin();
        test_masking();
        test_timeout();
        test_reset_mid_wait();
        test_stray_done();
        test_onehot();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
